// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//   Execute/writeback stage behind ARM_ALU. Each accepted ALU op is held in a
//   2-entry elastic buffer (head/tail) with valid/ready handshakes on both
//   sides. The stage also owns the architectural NZCV register and resolves
//   the ARM condition code of each op when it is accepted, so B.cond decisions
//   travel with the result.
//
// Ports
//   clk, rst_n     : single rising-edge clock, synchronous active-low reset
//   in_valid/ready : upstream handshake; ready depends on stored count only
//   in_f           : ALU result
//   in_status      : ALU status, [3]=N [2]=Z [1]=C [0]=V
//   in_set_flags   : op writes NZCV
//   in_we, in_rd   : register write request and destination index
//   in_is_bcond    : op is a conditional branch
//   in_cond        : ARM condition code
//   out_valid/ready: downstream handshake for the head entry
//   out_f, out_rd  : head result and destination
//   out_we         : head write enable, already cleared for the zero register
//   out_take       : head branch taken
//   flags          : architectural NZCV
module alu_writeback_stage #(
  parameter int DATA_W   = 64,
  parameter int RD_W     = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_f,
  input  logic [3:0]        in_status,
  input  logic              in_set_flags,
  input  logic              in_we,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_is_bcond,
  input  logic [3:0]        in_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_f,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              out_take,
  output logic [3:0]        flags
);

  // ARM condition evaluation against an NZCV nibble.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic base;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    // Odd codes invert the even condition, except 1111 which is also "always".
    if (cond[0] && (cond[3:1] != 3'b111)) begin
      base = ~base;
    end
    return base;
  endfunction

  logic [1:0]        count;
  logic [DATA_W-1:0] head_f,    tail_f;
  logic [RD_W-1:0]   head_rd,   tail_rd;
  logic              head_we,   tail_we;
  logic              head_take, tail_take;

  logic push;
  logic pop;
  logic new_we;
  logic new_take;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Condition uses flags before this op's own update, so a flag-setting op
  // pushed one cycle earlier is already visible here without any bypass.
  assign new_take = in_is_bcond && cond_true(in_cond, flags);
  assign new_we   = in_we && (in_rd != RD_W'(ZERO_REG));

  assign out_f    = head_f;
  assign out_rd   = head_rd;
  assign out_we   = head_we;
  assign out_take = head_take;

  // Buffer update: head changes only when a new op or the tail moves into it,
  // so an emptied buffer keeps showing the last popped entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      flags     <= 4'b0000;
      head_f    <= '0;
      head_rd   <= '0;
      head_we   <= 1'b0;
      head_take <= 1'b0;
      tail_f    <= '0;
      tail_rd   <= '0;
      tail_we   <= 1'b0;
      tail_take <= 1'b0;
    end else begin
      if (push && in_set_flags) begin
        flags <= in_status;
      end
      case (count)
        2'd0: begin
          if (push) begin
            head_f    <= in_f;
            head_rd   <= in_rd;
            head_we   <= new_we;
            head_take <= new_take;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_f    <= in_f;
            head_rd   <= in_rd;
            head_we   <= new_we;
            head_take <= new_take;
          end else if (push) begin
            tail_f    <= in_f;
            tail_rd   <= in_rd;
            tail_we   <= new_we;
            tail_take <= new_take;
            count     <= 2'd2;
          end else if (pop) begin
            count     <= 2'd0;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the tail.
          if (pop) begin
            head_f    <= tail_f;
            head_rd   <= tail_rd;
            head_we   <= tail_we;
            head_take <= tail_take;
            count     <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_f;
  logic [3:0]  in_status;
  logic        in_set_flags;
  logic        in_we;
  logic [4:0]  in_rd;
  logic        in_is_bcond;
  logic [3:0]  in_cond;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_f;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_take;
  logic [3:0]  flags;

  int checks;
  int failures;

  alu_writeback_stage #(.DATA_W(64), .RD_W(5), .ZERO_REG(31)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_f         (in_f),
    .in_status    (in_status),
    .in_set_flags (in_set_flags),
    .in_we        (in_we),
    .in_rd        (in_rd),
    .in_is_bcond  (in_is_bcond),
    .in_cond      (in_cond),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_f        (out_f),
    .out_rd       (out_rd),
    .out_we       (out_we),
    .out_take     (out_take),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, away from the sampling edge.
  task automatic set_in(input logic v, input logic [63:0] f, input logic [3:0] st,
                        input logic sf, input logic we, input logic [4:0] rd,
                        input logic bc, input logic [3:0] cond);
    @(negedge clk);
    in_valid     = v;
    in_f         = f;
    in_status    = st;
    in_set_flags = sf;
    in_we        = we;
    in_rd        = rd;
    in_is_bcond  = bc;
    in_cond      = cond;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0, 4'h0);
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0; in_f = 64'h0; in_status = 4'h0; in_set_flags = 1'b0;
    in_we = 1'b0; in_rd = 5'd0; in_is_bcond = 1'b0; in_cond = 4'h0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", flags, 4'b0000);
    check("rst_out_f", out_f, 0);
    check("rst_out_take", out_take, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op, one-cycle latency
    set_in(1, 64'hFF, 4'b0000, 1, 1, 5'd3, 0, 4'h0);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_f", out_f, 64'hFF);
    check("t1_we", out_we, 1);
    check("t1_rd", out_rd, 3);
    check("t1_flags", flags, 4'b0000);

    // SUBS setting Z, then B.EQ / B.NE back to back
    set_in(1, 64'h1, 4'b0100, 1, 1, 5'd4, 0, 4'h0);
    step();
    check("t2_flags", flags, 4'b0100);
    check("t2_f", out_f, 64'h1);
    set_in(1, 64'h2, 4'b0000, 0, 0, 5'd0, 1, 4'b0000);
    step();
    check("t2_beq_take", out_take, 1);
    check("t2_beq_f", out_f, 64'h2);
    set_in(1, 64'h3, 4'b0000, 0, 0, 5'd0, 1, 4'b0001);
    step();
    check("t2_bne_take", out_take, 0);
    check("t2_flags_hold", flags, 4'b0100);
    idle();
    check("t2_empty", out_valid, 0);
    check("t2_empty_hold_f", out_f, 64'h3);

    // Signed compares with N=1, V=1
    set_in(1, 64'h10, 4'b1001, 1, 0, 5'd0, 0, 4'h0);
    step();
    check("t3_flags", flags, 4'b1001);
    set_in(1, 64'h11, 4'b0000, 0, 0, 5'd0, 1, 4'b1010);
    step();
    check("t3_ge", out_take, 1);
    set_in(1, 64'h12, 4'b0000, 0, 0, 5'd0, 1, 4'b1100);
    step();
    check("t3_gt", out_take, 1);
    set_in(1, 64'h13, 4'b0000, 0, 0, 5'd0, 1, 4'b1011);
    step();
    check("t3_lt", out_take, 0);
    set_in(1, 64'h14, 4'b0000, 0, 0, 5'd0, 1, 4'b1000);
    step();
    check("t3_hi", out_take, 0);
    set_in(1, 64'h15, 4'b0000, 0, 0, 5'd0, 1, 4'b1111);
    step();
    check("t3_al", out_take, 1);
    set_in(1, 64'h16, 4'b0000, 0, 0, 5'd0, 0, 4'b1111);
    step();
    check("t3_not_bcond", out_take, 0);
    idle();

    // Backpressure: three ops, only two accepted
    @(negedge clk);
    out_ready = 1'b0;
    set_in(1, 64'hA1, 4'b0000, 0, 1, 5'd1, 0, 4'h0);
    step();
    check("t4_in_ready_1", in_ready, 1);
    set_in(1, 64'hB2, 4'b0000, 0, 1, 5'd2, 0, 4'h0);
    step();
    check("t4_full", in_ready, 0);
    check("t4_hold_f", out_f, 64'hA1);
    set_in(1, 64'hC3, 4'b0010, 1, 1, 5'd5, 0, 4'h0);
    step();
    check("t4_still_full", in_ready, 0);
    check("t4_hold_f2", out_f, 64'hA1);
    check("t4_no_flag_upd", flags, 4'b1001);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    check("t4_drain_b", out_f, 64'hB2);
    check("t4_drain_b_rd", out_rd, 2);
    check("t4_ready_again", in_ready, 1);
    step();
    check("t4_drain_c", out_f, 64'hC3);
    check("t4_flags_c", flags, 4'b0010);
    idle();
    check("t4_empty", out_valid, 0);
    check("t4_empty_f", out_f, 64'hC3);

    // Zero register and non-flag ops
    set_in(1, 64'h55, 4'b0000, 0, 1, 5'd31, 0, 4'h0);
    step();
    check("t5_xzr_we", out_we, 0);
    set_in(1, 64'h66, 4'b1111, 0, 1, 5'd30, 0, 4'h0);
    step();
    check("t5_r30_we", out_we, 1);
    check("t5_flags_unch", flags, 4'b0010);
    idle();

    // Reset while full
    @(negedge clk);
    out_ready = 1'b0;
    set_in(1, 64'h77, 4'b0110, 1, 1, 5'd7, 0, 4'h0);
    step();
    set_in(1, 64'h88, 4'b0000, 0, 1, 5'd8, 0, 4'h0);
    step();
    check("t6_full", in_ready, 0);
    check("t6_flags", flags, 4'b0110);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_flags", flags, 4'b0000);
    check("t6_rst_f", out_f, 0);
    check("t6_rst_we", out_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("t6_ready", in_ready, 1);
    check("t6_valid_after", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
